tlb_cp0_ctrl: RTL and testbench

- Sits between the writeback-stage CP0 logic and the 16-entry dual-search-port TLB.
- Holds the TLB-related CP0 registers: Index, Random, EntryLo0, EntryLo1 and EntryHi.
- Sequences TLBP, TLBR, TLBWI and TLBWR through a small state machine that drives the TLB's search port 1, read port and write port.
- Supplies the current ASID to the fetch/load search port 0.

---
 rtl/tlb_cp0_pkg.sv | 50 +++++
 rtl/tlb_cp0_ctrl_if.sv | 62 ++++++
 rtl/tlb_random_cnt.sv | 22 ++
 rtl/tlb_cp0_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_tlb_cp0_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tlb_cp0_pkg.sv
// Shared definitions for the TLB CP0 controller: TLB geometry, CP0 register
// addresses ({rd,sel}), register field positions and the sequencer states.
package tlb_cp0_pkg;

    localparam int TLBNUM = 16;
    localparam int IW     = $clog2(TLBNUM);

    // CP0 register addresses, sel 0
    localparam logic [7:0] CP0_INDEX    = 8'h00;
    localparam logic [7:0] CP0_RANDOM   = 8'h08;
    localparam logic [7:0] CP0_ENTRYLO0 = 8'h10;
    localparam logic [7:0] CP0_ENTRYLO1 = 8'h18;
    localparam logic [7:0] CP0_ENTRYHI  = 8'h50;

    // Index fields
    localparam int INDEX_P_BIT = 31;

    // EntryLo fields
    localparam int LO_PFN_MSB = 25;
    localparam int LO_PFN_LSB = 6;
    localparam int LO_C_MSB   = 5;
    localparam int LO_C_LSB   = 3;
    localparam int LO_D_BIT   = 2;
    localparam int LO_V_BIT   = 1;
    localparam int LO_G_BIT   = 0;

    // EntryHi fields
    localparam int HI_VPN2_MSB = 31;
    localparam int HI_VPN2_LSB = 13;
    localparam int HI_ASID_MSB = 7;
    localparam int HI_ASID_LSB = 0;

    // Member order mirrors the EntryLo bit layout, so a [25:0] slice maps 1:1.
    typedef struct packed {
        logic [19:0] pfn;
        logic [2:0]  c;
        logic        d;
        logic        v;
        logic        g;
    } entrylo_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PROBE,
        ST_READ,
        ST_WRITE,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tlb_cp0_ctrl_if.sv
// Bus between the CP0 controller and the TLB: search port 1, read port and
// write port. The controller is the master, the TLB is the slave.
interface tlb_cp0_ctrl_if;
    import tlb_cp0_pkg::*;

    // search port 1
    logic [18:0]   s1_vpn2;
    logic          s1_odd_page;
    logic [7:0]    s1_asid;
    logic          s1_found;
    logic [IW-1:0] s1_index;

    // write port
    logic          we;
    logic [IW-1:0] w_index;
    logic [18:0]   w_vpn2;
    logic [7:0]    w_asid;
    logic          w_g;
    logic [19:0]   w_pfn0;
    logic [2:0]    w_c0;
    logic          w_d0;
    logic          w_v0;
    logic [19:0]   w_pfn1;
    logic [2:0]    w_c1;
    logic          w_d1;
    logic          w_v1;

    // read port
    logic [IW-1:0] r_index;
    logic [18:0]   r_vpn2;
    logic [7:0]    r_asid;
    logic          r_g;
    logic [19:0]   r_pfn0;
    logic [2:0]    r_c0;
    logic          r_d0;
    logic          r_v0;
    logic [19:0]   r_pfn1;
    logic [2:0]    r_c1;
    logic          r_d1;
    logic          r_v1;

    modport master (
        output s1_vpn2, s1_odd_page, s1_asid,
        input  s1_found, s1_index,
        output we, w_index, w_vpn2, w_asid, w_g,
        output w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        output r_index,
        input  r_vpn2, r_asid, r_g,
        input  r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );

    modport slave (
        input  s1_vpn2, s1_odd_page, s1_asid,
        output s1_found, s1_index,
        input  we, w_index, w_vpn2, w_asid, w_g,
        input  w_pfn0, w_c0, w_d0, w_v0, w_pfn1, w_c1, w_d1, w_v1,
        input  r_index,
        output r_vpn2, r_asid, r_g,
        output r_pfn0, r_c0, r_d0, r_v0, r_pfn1, r_c1, r_d1, r_v1
    );

endinterface

// File: rtl/tlb_random_cnt.sv
// CP0 Random: free-running down-counter over the TLB entries, wrapping from
// 0 back to TLBNUM-1. Only instantiated when TLB_RANDOM_EN is defined.
module tlb_random_cnt #(
    parameter int TLBNUM = 16,
    parameter int IW     = $clog2(TLBNUM)
) (
    input  logic          clk,
    input  logic          reset,
    output logic [IW-1:0] count
);

    // Decrement every cycle; restart from the top entry after 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= IW'(TLBNUM - 1);
        else if (count == '0)
            count <= IW'(TLBNUM - 1);
        else
            count <= count - 1'b1;
    end

endmodule

// File: rtl/tlb_cp0_ctrl.sv
// TLB CP0 controller: owns Index, Random, EntryLo0/1 and EntryHi, sequences
// TLBP/TLBR/TLBWI/TLBWR over the TLB bus and exports the current ASID.
// Optional feature macro: TLB_RANDOM_EN (Random register and TLBWR writes).
module tlb_cp0_ctrl
    import tlb_cp0_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  op_valid,
    input  logic                  op_tlbp,
    input  logic                  op_tlbr,
    input  logic                  op_tlbwi,
    input  logic                  op_tlbwr,
    output logic                  op_ready,
    output logic                  op_done,

    input  logic                  mtc0_we,
    input  logic [7:0]            mtc0_addr,
    input  logic [31:0]           mtc0_wdata,
    input  logic [7:0]            mfc0_addr,
    output logic [31:0]           mfc0_rdata,

    input  logic                  exc_tlb_we,
    input  logic [31:0]           exc_vaddr,

    output logic [7:0]            cur_asid,

    tlb_cp0_ctrl_if.master        tlb
);

    state_t        state;
    logic          wr_random;      // current WRITE is a TLBWR

    logic          index_p;
    logic [IW-1:0] index_idx;
    entrylo_t      lo0;
    entrylo_t      lo1;
    logic [18:0]   hi_vpn2;
    logic [7:0]    hi_asid;
    logic [31:0]   random_word;

    logic mtc0_index;
    logic mtc0_lo0;
    logic mtc0_lo1;
    logic mtc0_hi;

    assign mtc0_index = mtc0_we && (mtc0_addr == CP0_INDEX);
    assign mtc0_lo0   = mtc0_we && (mtc0_addr == CP0_ENTRYLO0);
    assign mtc0_lo1   = mtc0_we && (mtc0_addr == CP0_ENTRYLO1);
    assign mtc0_hi    = mtc0_we && (mtc0_addr == CP0_ENTRYHI);

    // Sequencer: accept in IDLE, one action cycle, one DONE cycle, back to IDLE.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state     <= ST_IDLE;
            op_ready  <= 1'b1;
            op_done   <= 1'b0;
            wr_random <= 1'b0;
        end else begin
            op_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (op_valid && op_ready) begin
                        if (op_tlbp) begin
                            state    <= ST_PROBE;
                            op_ready <= 1'b0;
                        end else if (op_tlbr) begin
                            state    <= ST_READ;
                            op_ready <= 1'b0;
                        end else if (op_tlbwi || op_tlbwr) begin
                            state     <= ST_WRITE;
                            op_ready  <= 1'b0;
                            wr_random <= op_tlbwr;
                        end
                    end
                end
                ST_PROBE, ST_READ, ST_WRITE: begin
                    state   <= ST_DONE;
                    op_done <= 1'b1;
                end
                ST_DONE: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
                default: begin
                    state    <= ST_IDLE;
                    op_ready <= 1'b1;
                end
            endcase
        end
    end

    // Index: probe result beats MTC0; P is only ever written by the probe.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            index_p   <= 1'b0;
            index_idx <= '0;
        end else if (state == ST_PROBE) begin
            index_p <= ~tlb.s1_found;
            if (tlb.s1_found)
                index_idx <= tlb.s1_index;
        end else if (mtc0_index) begin
            index_idx <= mtc0_wdata[IW-1:0];
        end
    end

    // EntryLo0/1: TLBR result beats MTC0; G is replicated into both halves.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lo0 <= '0;
            lo1 <= '0;
        end else if (state == ST_READ) begin
            lo0 <= {tlb.r_pfn0, tlb.r_c0, tlb.r_d0, tlb.r_v0, tlb.r_g};
            lo1 <= {tlb.r_pfn1, tlb.r_c1, tlb.r_d1, tlb.r_v1, tlb.r_g};
        end else begin
            if (mtc0_lo0)
                lo0 <= mtc0_wdata[LO_PFN_MSB:LO_G_BIT];
            if (mtc0_lo1)
                lo1 <= mtc0_wdata[LO_PFN_MSB:LO_G_BIT];
        end
    end

    // EntryHi: TLBR beats an exception commit, which beats MTC0 as a whole.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_vpn2 <= '0;
            hi_asid <= '0;
        end else if (state == ST_READ) begin
            hi_vpn2 <= tlb.r_vpn2;
            hi_asid <= tlb.r_asid;
        end else if (exc_tlb_we) begin
            hi_vpn2 <= exc_vaddr[HI_VPN2_MSB:HI_VPN2_LSB];
        end else if (mtc0_hi) begin
            hi_vpn2 <= mtc0_wdata[HI_VPN2_MSB:HI_VPN2_LSB];
            hi_asid <= mtc0_wdata[HI_ASID_MSB:HI_ASID_LSB];
        end
    end

`ifdef TLB_RANDOM_EN
    logic [IW-1:0] random_val;

    tlb_random_cnt #(.TLBNUM(TLBNUM), .IW(IW)) u_random (
        .clk   (clk),
        .reset (reset),
        .count (random_val)
    );

    assign random_word = 32'(random_val);
    assign tlb.we      = (state == ST_WRITE);
    assign tlb.w_index = wr_random ? random_val : index_idx;
`else
    // Without Random, TLBWR sequences normally but never writes.
    assign random_word = '0;
    assign tlb.we      = (state == ST_WRITE) && !wr_random;
    assign tlb.w_index = index_idx;
`endif

    // TLB bus fields come straight from the registers; only we is state-gated.
    assign tlb.s1_vpn2     = hi_vpn2;
    assign tlb.s1_asid     = hi_asid;
    assign tlb.s1_odd_page = 1'b0;
    assign tlb.r_index     = index_idx;
    assign tlb.w_vpn2      = hi_vpn2;
    assign tlb.w_asid      = hi_asid;
    assign tlb.w_g         = lo0.g & lo1.g;
    assign tlb.w_pfn0      = lo0.pfn;
    assign tlb.w_c0        = lo0.c;
    assign tlb.w_d0        = lo0.d;
    assign tlb.w_v0        = lo0.v;
    assign tlb.w_pfn1      = lo1.pfn;
    assign tlb.w_c1        = lo1.c;
    assign tlb.w_d1        = lo1.d;
    assign tlb.w_v1        = lo1.v;

    assign cur_asid = hi_asid;

    // MFC0 read mux; unimplemented bits and unmapped addresses read 0.
    always_comb begin
        // NOTE: default assignment first, so every path drives the output and no latch is inferred.
        mfc0_rdata = '0;
        case (mfc0_addr)
            CP0_INDEX: begin
                mfc0_rdata[INDEX_P_BIT] = index_p;
                mfc0_rdata[IW-1:0]      = index_idx;
            end
            CP0_RANDOM:   mfc0_rdata = random_word;
            CP0_ENTRYLO0: mfc0_rdata[LO_PFN_MSB:LO_G_BIT] = lo0;
            CP0_ENTRYLO1: mfc0_rdata[LO_PFN_MSB:LO_G_BIT] = lo1;
            CP0_ENTRYHI: begin
                mfc0_rdata[HI_VPN2_MSB:HI_VPN2_LSB] = hi_vpn2;
                mfc0_rdata[HI_ASID_MSB:HI_ASID_LSB] = hi_asid;
            end
            default: ;
        endcase
    end

    // Bits of the data buses that no register implements.
    logic unused_bits;
    assign unused_bits = ^{mtc0_wdata[12:8], exc_vaddr[12:0]};

endmodule

// File: tb/tb_tlb_cp0_ctrl.sv
// Self-checking bench for tlb_cp0_ctrl: directed test-plan steps followed by
// randomized ops and CP0 traffic, checked against a register-level model.
module tb_tlb_cp0_ctrl;
    import tlb_cp0_pkg::*;

    typedef struct packed {
        logic [18:0] vpn2;
        logic [7:0]  asid;
        logic        g;
        logic [19:0] pfn0;
        logic [2:0]  c0;
        logic        d0;
        logic        v0;
        logic [19:0] pfn1;
        logic [2:0]  c1;
        logic        d1;
        logic        v1;
    } tlb_entry_t;

    localparam int K_NONE = 0, K_PROBE = 1, K_READ = 2, K_WRITE = 3;
    localparam int OP_P = 0, OP_R = 1, OP_WI = 2, OP_WR = 3;

`ifdef TLB_RANDOM_EN
    localparam bit RANDOM_EN = 1'b1;
`else
    localparam bit RANDOM_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        op_valid = 0, op_tlbp = 0, op_tlbr = 0, op_tlbwi = 0, op_tlbwr = 0;
    logic        op_ready, op_done;
    logic        mtc0_we = 0;
    logic [7:0]  mtc0_addr = 0;
    logic [31:0] mtc0_wdata = 0;
    logic [7:0]  mfc0_addr = 0;
    logic [31:0] mfc0_rdata;
    logic        exc_tlb_we = 0;
    logic [31:0] exc_vaddr = 0;
    logic [7:0]  cur_asid;

    int checks = 0;
    int failures = 0;
    int edges = 0;

    // model state: architectural register images
    logic [31:0] m_index = 0, m_lo0 = 0, m_lo1 = 0, m_hi = 0;
    tlb_entry_t  tlb_mem [TLBNUM];

    always #10 clk = ~clk;

    tlb_cp0_ctrl_if bus();

    tlb_cp0_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .op_valid   (op_valid),
        .op_tlbp    (op_tlbp),
        .op_tlbr    (op_tlbr),
        .op_tlbwi   (op_tlbwi),
        .op_tlbwr   (op_tlbwr),
        .op_ready   (op_ready),
        .op_done    (op_done),
        .mtc0_we    (mtc0_we),
        .mtc0_addr  (mtc0_addr),
        .mtc0_wdata (mtc0_wdata),
        .mfc0_addr  (mfc0_addr),
        .mfc0_rdata (mfc0_rdata),
        .exc_tlb_we (exc_tlb_we),
        .exc_vaddr  (exc_vaddr),
        .cur_asid   (cur_asid),
        .tlb        (bus)
    );

    // Behavioural TLB read port
    assign bus.r_vpn2 = tlb_mem[bus.r_index].vpn2;
    assign bus.r_asid = tlb_mem[bus.r_index].asid;
    assign bus.r_g    = tlb_mem[bus.r_index].g;
    assign bus.r_pfn0 = tlb_mem[bus.r_index].pfn0;
    assign bus.r_c0   = tlb_mem[bus.r_index].c0;
    assign bus.r_d0   = tlb_mem[bus.r_index].d0;
    assign bus.r_v0   = tlb_mem[bus.r_index].v0;
    assign bus.r_pfn1 = tlb_mem[bus.r_index].pfn1;
    assign bus.r_c1   = tlb_mem[bus.r_index].c1;
    assign bus.r_d1   = tlb_mem[bus.r_index].d1;
    assign bus.r_v1   = tlb_mem[bus.r_index].v1;

    // Clock edges since reset release: Random counts down once per edge.
    always @(posedge clk or posedge reset) begin
        if (reset) edges <= 0;
        else       edges <= edges + 1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_random();
        if (!RANDOM_EN) return 32'h0;
        return 32'((TLBNUM - 1) - (edges % TLBNUM));
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        case (a)
            8'h00:   return m_index;
            8'h08:   return exp_random();
            8'h10:   return m_lo0;
            8'h18:   return m_lo1;
            8'h50:   return m_hi;
            default: return 32'h0;
        endcase
    endfunction

    // Apply the architectural effect of the clock edge just taken.
    // kind names the op action that was in progress during that cycle.
    task automatic model_update(input int kind);
        bit fsm_idx, fsm_hilo;
        tlb_entry_t e;
        fsm_idx  = (kind == K_PROBE);
        fsm_hilo = (kind == K_READ);
        if (fsm_idx) begin
            if (bus.s1_found) m_index = 32'(bus.s1_index);
            else              m_index = m_index | 32'h8000_0000;
        end
        if (fsm_hilo) begin
            e = tlb_mem[m_index[IW-1:0]];
            m_hi  = {e.vpn2, 5'b0, e.asid};
            m_lo0 = {6'b0, e.pfn0, e.c0, e.d0, e.v0, e.g};
            m_lo1 = {6'b0, e.pfn1, e.c1, e.d1, e.v1, e.g};
        end
        if (exc_tlb_we && !fsm_hilo)
            m_hi = {exc_vaddr[31:13], m_hi[12:0]};
        if (mtc0_we) begin
            case (mtc0_addr)
                8'h00: if (!fsm_idx) m_index = (m_index & 32'h8000_0000) | (mtc0_wdata & 32'(TLBNUM - 1));
                8'h10: if (!fsm_hilo) m_lo0 = mtc0_wdata & 32'h03FF_FFFF;
                8'h18: if (!fsm_hilo) m_lo1 = mtc0_wdata & 32'h03FF_FFFF;
                8'h50: if (!fsm_hilo && !exc_tlb_we) m_hi = mtc0_wdata & 32'hFFFF_E0FF;
                default: ;
            endcase
        end
    endtask

    task automatic advance(input int kind);
        @(negedge clk);
        model_update(kind);
        mtc0_we    = 1'b0;
        exc_tlb_we = 1'b0;
    endtask

    task automatic check_regs(input string tag);
        logic [7:0] addrs [6];
        addrs = '{8'h00, 8'h08, 8'h10, 8'h18, 8'h50, 8'($urandom_range(0, 255))};
        for (int i = 0; i < 6; i++) begin
            mfc0_addr = addrs[i];
            #1;
            check($sformatf("%s_mfc0_%02h", tag, addrs[i]), mfc0_rdata, model_read(addrs[i]));
        end
        check($sformatf("%s_asid", tag), cur_asid, m_hi[7:0]);
    endtask

    task automatic rand_side();
        mtc0_we    = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
            0:       mtc0_addr = 8'h00;
            1:       mtc0_addr = 8'h08;
            2:       mtc0_addr = 8'h10;
            3:       mtc0_addr = 8'h18;
            4:       mtc0_addr = 8'h50;
            default: mtc0_addr = 8'($urandom_range(0, 255));
        endcase
        mtc0_wdata = $urandom;
        exc_tlb_we = ($urandom_range(0, 3) == 0);
        exc_vaddr  = $urandom;
    endtask

    // One full op: accept (cycle 0), action (1), done (2), ready again (3).
    // Called at a negedge; any mtc0/exc already driven belongs to cycle 0.
    task automatic run_op(input int op, input bit side0, input bit side1,
                          input bit found, input int sidx, input string tag);
        int          kind;
        logic        exp_we;
        logic [31:0] rnd;
        logic [IW-1:0] exp_widx;
        tlb_entry_t  exp_ent;
        kind = (op == OP_P) ? K_PROBE : (op == OP_R) ? K_READ : K_WRITE;
        if (side0) rand_side();
        op_valid = 1'b1;
        op_tlbp  = (op == OP_P);
        op_tlbr  = (op == OP_R);
        op_tlbwi = (op == OP_WI);
        op_tlbwr = (op == OP_WR);
        #1;
        check({tag, "_ready_c0"}, op_ready, 1'b1);
        advance(K_NONE);
        // cycle 1: request still held by WB, must be ignored
        if (side1) rand_side();
        bus.s1_found = found;
        bus.s1_index = IW'(sidx);
        #1;
        exp_we   = 1'b0;
        exp_widx = '0;
        exp_ent  = '0;
        case (kind)
            K_PROBE: check({tag, "_probe_bus"}, {bus.s1_vpn2, bus.s1_asid, bus.s1_odd_page, bus.we},
                           {m_hi[31:13], m_hi[7:0], 1'b0, 1'b0});
            K_READ:  check({tag, "_read_bus"}, {bus.r_index, bus.we}, {m_index[IW-1:0], 1'b0});
            default: begin
                rnd      = exp_random();
                exp_we   = (op == OP_WI) || RANDOM_EN;
                exp_widx = (op == OP_WR) ? rnd[IW-1:0] : m_index[IW-1:0];
                exp_ent  = {m_hi[31:13], m_hi[7:0], m_lo0[0] & m_lo1[0],
                            m_lo0[25:6], m_lo0[5:3], m_lo0[2], m_lo0[1],
                            m_lo1[25:6], m_lo1[5:3], m_lo1[2], m_lo1[1]};
                check({tag, "_we"}, bus.we, exp_we);
                if (exp_we) begin
                    check({tag, "_w_index"}, bus.w_index, exp_widx);
                    check({tag, "_w_fields"},
                          {bus.w_vpn2, bus.w_asid, bus.w_g, bus.w_pfn0, bus.w_c0, bus.w_d0, bus.w_v0,
                           bus.w_pfn1, bus.w_c1, bus.w_d1, bus.w_v1}, exp_ent);
                end
            end
        endcase
        advance(kind);
        if (exp_we) tlb_mem[exp_widx] = exp_ent;
        // cycle 2: done pulse, register update visible
        #1;
        check({tag, "_done_c2"}, {op_done, op_ready, bus.we}, 3'b100);
        check_regs(tag);
        op_valid = 1'b0;
        op_tlbp = 0; op_tlbr = 0; op_tlbwi = 0; op_tlbwr = 0;
        advance(K_NONE);
        #1;
        check({tag, "_ready_c3"}, {op_ready, op_done}, 2'b10);
    endtask

    initial begin
        logic [95:0] r96;
        bus.s1_found = 1'b0;
        bus.s1_index = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            r96 = {$urandom, $urandom, $urandom};
            tlb_mem[i] = r96[77:0];
        end

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_ctrl", {op_ready, op_done, bus.we}, 3'b100);
        check_regs("rst");
        @(negedge clk);
        reset = 1'b0;

        // TLBP hit
        mtc0_we = 1; mtc0_addr = 8'h50; mtc0_wdata = 32'h0000_2005;
        advance(K_NONE);
        run_op(OP_P, 0, 0, 1'b1, 5, "tlbp_hit");
        check("tlbp_hit_index", m_index, 32'h0000_0005);

        // TLBP miss: P set, index kept
        run_op(OP_P, 0, 0, 1'b0, 9, "tlbp_miss");

        // TLBWI with Index written in the accept cycle
        mtc0_we = 1; mtc0_addr = 8'h10; mtc0_wdata = 32'h0000_004F;
        advance(K_NONE);
        mtc0_we = 1; mtc0_addr = 8'h18; mtc0_wdata = 32'h0000_008E;
        advance(K_NONE);
        mtc0_we = 1; mtc0_addr = 8'h00; mtc0_wdata = 32'h0000_0003;
        run_op(OP_WI, 0, 0, 1'b0, 0, "tlbwi");

        // TLBR at index 7
        tlb_mem[7].vpn2 = 19'h12345;
        tlb_mem[7].asid = 8'h3A;
        tlb_mem[7].g    = 1'b1;
        mtc0_we = 1; mtc0_addr = 8'h00; mtc0_wdata = 32'h0000_0007;
        advance(K_NONE);
        run_op(OP_R, 0, 0, 1'b0, 0, "tlbr");

        // EntryHi MTC0 colliding with an exception commit
        mtc0_we = 1; mtc0_addr = 8'h50; mtc0_wdata = 32'h1234_5677;
        exc_tlb_we = 1; exc_vaddr = 32'hBFC0_2000;
        advance(K_NONE);
        #1;
        check_regs("exc_vs_mtc0");

        // TLBWR
        @(negedge clk);
        run_op(OP_WR, 0, 0, 1'b0, 0, "tlbwr");

        // Randomized ops with CP0 traffic around and inside them
        for (int n = 0; n < 60; n++) begin
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                rand_side();
                advance(K_NONE);
                #1;
                check_regs($sformatf("idle%0d", n));
            end
            run_op(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), int'($urandom_range(0, TLBNUM - 1)),
                   $sformatf("rnd%0d", n));
        end

        // Reset asserted in the middle of a WRITE cycle
        mtc0_we = 1; mtc0_addr = 8'h00; mtc0_wdata = 32'h0000_000A;
        op_valid = 1; op_tlbwi = 1;
        advance(K_NONE);
        #1;
        check("rst_mid_we_before", bus.we, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("rst_mid_we_async", {bus.we, op_ready, op_done}, 3'b010);
        op_valid = 0; op_tlbwi = 0;
        m_index = 0; m_lo0 = 0; m_lo1 = 0; m_hi = 0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_ready", {op_ready, op_done, bus.we}, 3'b100);
        check_regs("rst_mid");
        @(negedge clk);
        run_op(OP_WI, 0, 0, 1'b0, 0, "post_rst_tlbwi");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
